hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the single-operand execute-stage forwarding mux. It covers NUM_SRC source operands and owns both forwarding-select generation and load-use hazard control.
- Sits between the D/E/M/W pipeline registers and the ALU operand inputs.
- Drives forwarded operands, fetch/decode stall and decode/execute flush.
- A small FSM inserts LOAD_LAT bubbles on a load-use hazard. Branch mispredict flush overrides it.

Parameters:
- XLEN, 32, datapath width.
- NUM_SRC, 2, number of source operands per instruction (3 for fused/FMA-style ops).
- REG_AW, 5, register address width.
- LOAD_LAT, 1, bubbles per load-use hazard; legal range 1..7.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rs_addr_D  in  NUM_SRC x REG_AW  source addresses in Decode
- rs_used_D  in  NUM_SRC  source actually read by the Decode instruction
- rs_addr_E  in  NUM_SRC x REG_AW  source addresses in Execute
- rs_data_E  in  NUM_SRC x XLEN  register-file data in Execute
- rd_addr_E / rd_wren_E / is_load_E  in  REG_AW/1/1  Execute producer
- rd_addr_M / rd_wren_M / is_load_M  in  REG_AW/1/1  Memory producer
- alu_data_M  in  XLEN  ALU result in Memory
- rd_addr_W / rd_wren_W  in  REG_AW/1  Write-back producer
- wb_data_W  in  XLEN  write-back data
- mispredict_E  in  1  branch mispredict resolved in Execute
- src_E  out  NUM_SRC x XLEN  forwarded ALU operands
- fwd_sel_E  out  NUM_SRC x 2  select per operand (debug/perf)
- stall_F, stall_D  out  1  hold PC and F/D register
- flush_D, flush_E  out  1  bubble D/E register

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE, cnt=0. While in reset, stall_F/stall_D/flush_D/flush_E=0. src_E/fwd_sel_E remain combinational.

Forwarding (combinational, per operand i):
- FWD_MEM (2'b10) if rd_wren_M && rd_addr_M==rs_addr_E[i] && rs_addr_E[i]!=0 && !is_load_M.
- Else FWD_WB (2'b01) if rd_wren_W && rd_addr_W==rs_addr_E[i] && rs_addr_E[i]!=0.
- Else FWD_RF (2'b00).
- Memory has priority over Write-back. x0 is never forwarded.
- A load in M is never forwarded; the hazard FSM guarantees the consumer sees it from W or the RF.
- src_E[i] = alu_data_M / wb_data_W / rs_data_E[i] per select. There is no width conversion; all are XLEN.

Hazard detect (combinational):
- hz = is_load_E && rd_wren_E && rd_addr_E!=0 && OR_i(rs_used_D[i] && rs_addr_D[i]==rd_addr_E).

FSM:
- IDLE: if mispredict_E, assert flush_D=flush_E=1 and stay in IDLE. Else if hz, assert stall_F=stall_D=flush_E=1.
  - If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1. Otherwise stay in IDLE.
- STALL: stall_F=stall_D=flush_E=1, cnt decrements each cycle; when cnt==1, next state is IDLE.
  - Total bubbles are exactly LOAD_LAT.
- Mispredict in any state has priority over stall: stall_F=stall_D=0, flush_D=flush_E=1, next state IDLE, cnt=0.
- A new hz in the IDLE cycle immediately after STALL is evaluated normally (back-to-back loads).
- Reset mid-STALL aborts to IDLE; the first cycle after release has no stall.
- cnt width = 3 bits. LOAD_LAT outside 1..7 fails an elaboration-time assertion.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 (2'b11 unused; the mux treats it as FWD_RF).
  - hz_state_e enum: IDLE, STALL.
  - CNT_W=3.
- Sub-module fwd_operand_mux (XLEN): one select plus three data inputs. It is instantiated NUM_SRC times in a generate loop.
- Select logic and FSM stay in the top module.

Test Plan:
- ALU dependency: E reads x5, M writes x5 (alu_data_M=32'hDEAD_BEEF), W writes x5 (wb_data_W=32'h1234) -> src_E[0]=32'hDEAD_BEEF, fwd_sel_E[0]=2'b10, no stall.
- x0 guard: rs_addr_E[1]=0, rd_wren_M=1, rd_addr_M=0 -> src_E[1]=rs_data_E[1], fwd_sel=2'b00.
- Load-use, LOAD_LAT=1: load x7 in E, D uses x7 on src 1 -> exactly one cycle of stall_F/stall_D/flush_E=1. Two cycles later the consumer in E gets fwd_sel_E[1]=2'b01 with wb_data_W.
- Load-use, LOAD_LAT=3: same stimulus -> stall asserted exactly 3 consecutive cycles, then deasserted. A load in M with matching rd never selects FWD_MEM.
- Mispredict during STALL (LOAD_LAT=3, mispredict_E in 2nd stall cycle) -> that cycle stall_F=0, flush_D=flush_E=1; next cycle IDLE with all controls 0.
- Async reset mid-STALL: rst_ni low for half a cycle -> outputs 0 immediately, no residual stall after release. rs_used_D=0 with a matching address -> no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the execute-stage forwarding and load-use hazard logic.
// Select encodings, hazard FSM states and the bubble counter width.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  localparam int CNT_W = 3;

endpackage

// File: rtl/fwd_operand_mux.sv
// One ALU operand: picks RF, write-back or memory-stage data.
// The unused select code falls back to the register file.
module fwd_operand_mux
  import hazard_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] data
);

  always_comb begin
    data = rf_data;
    case (sel)
      FWD_WB:  data = wb_data;
      FWD_MEM: data = mem_data;
      default: data = rf_data;
    endcase
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding for NUM_SRC sources plus load-use stall control.
// A load-use hazard costs LOAD_LAT bubbles; a mispredict flush wins.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]   rs_addr_D,
  input  logic [NUM_SRC-1:0]               rs_used_D,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]   rs_addr_E,
  input  logic [NUM_SRC-1:0][XLEN-1:0]     rs_data_E,
  input  logic [REG_AW-1:0]                rd_addr_E,
  input  logic                             rd_wren_E,
  input  logic                             is_load_E,
  input  logic [REG_AW-1:0]                rd_addr_M,
  input  logic                             rd_wren_M,
  input  logic                             is_load_M,
  input  logic [XLEN-1:0]                  alu_data_M,
  input  logic [REG_AW-1:0]                rd_addr_W,
  input  logic                             rd_wren_W,
  input  logic [XLEN-1:0]                  wb_data_W,
  input  logic                             mispredict_E,
  output logic [NUM_SRC-1:0][XLEN-1:0]     src_E,
  output logic [NUM_SRC-1:0][1:0]          fwd_sel_E,
  output logic                             stall_F,
  output logic                             stall_D,
  output logic                             flush_D,
  output logic                             flush_E
);

  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_lat
    $fatal(1, "LOAD_LAT must be in 1..7");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_sel_e sel;

    always_comb begin
      sel = FWD_RF;
      if (rd_wren_M && rd_addr_M == rs_addr_E[i] &&
          |rs_addr_E[i] && !is_load_M)
        sel = FWD_MEM;
      else if (rd_wren_W && rd_addr_W == rs_addr_E[i] &&
               |rs_addr_E[i])
        sel = FWD_WB;
    end

    assign fwd_sel_E[i] = sel;

    fwd_operand_mux #(.XLEN(XLEN)) u_mux (
      .sel      (sel),
      .rf_data  (rs_data_E[i]),
      .wb_data  (wb_data_W),
      .mem_data (alu_data_M),
      .data     (src_E[i])
    );
  end

  logic use_hit;
  logic hz;

  always_comb begin
    use_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      use_hit = use_hit |
                (rs_used_D[i] && rs_addr_D[i] == rd_addr_E);
  end

  assign hz = is_load_E && rd_wren_E && |rd_addr_E && use_hit;

  hz_state_e        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (mispredict_E) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hz && LOAD_LAT > 1) begin
            state <= STALL;
            cnt   <= CNT_INIT;
          end
        end
        STALL: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= IDLE;
        end
      endcase
    end
  end

  // The first bubble is raised in IDLE the cycle the hazard is seen.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (rst_ni) begin
      if (mispredict_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (state == STALL || hz) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed and random checks of forwarding and load-use control
// against a bubble-budget reference model, for LOAD_LAT of 1 and 3.
module tb_hazard_forward_unit;

  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  logic [NS-1:0][AW-1:0]   rs_addr_D, rs_addr_E;
  logic [NS-1:0]           rs_used_D;
  logic [NS-1:0][XLEN-1:0] rs_data_E;
  logic [AW-1:0]           rd_addr_E, rd_addr_M, rd_addr_W;
  logic                    rd_wren_E, rd_wren_M, rd_wren_W;
  logic                    is_load_E, is_load_M;
  logic [XLEN-1:0]         alu_data_M, wb_data_W;
  logic                    mispredict_E;

  logic [NS-1:0][XLEN-1:0] src1, src3;
  logic [NS-1:0][1:0]      sel1, sel3;
  logic sf1, sd1, fd1, fe1;
  logic sf3, sd3, fd3, fe3;

  logic [3:0] ctl [2];
  assign ctl[0] = {sf1, sd1, fd1, fe1};
  assign ctl[1] = {sf3, sd3, fd3, fe3};

  int lat [2] = '{1, 3};
  int rem [2];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .XLEN(XLEN), .NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(1)
  ) u_ll1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .rs_addr_D(rs_addr_D), .rs_used_D(rs_used_D),
    .rs_addr_E(rs_addr_E), .rs_data_E(rs_data_E),
    .rd_addr_E(rd_addr_E), .rd_wren_E(rd_wren_E),
    .is_load_E(is_load_E),
    .rd_addr_M(rd_addr_M), .rd_wren_M(rd_wren_M),
    .is_load_M(is_load_M), .alu_data_M(alu_data_M),
    .rd_addr_W(rd_addr_W), .rd_wren_W(rd_wren_W),
    .wb_data_W(wb_data_W), .mispredict_E(mispredict_E),
    .src_E(src1), .fwd_sel_E(sel1),
    .stall_F(sf1), .stall_D(sd1),
    .flush_D(fd1), .flush_E(fe1)
  );

  hazard_forward_unit #(
    .XLEN(XLEN), .NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(3)
  ) u_ll3 (
    .clk_i(clk), .rst_ni(rst_ni),
    .rs_addr_D(rs_addr_D), .rs_used_D(rs_used_D),
    .rs_addr_E(rs_addr_E), .rs_data_E(rs_data_E),
    .rd_addr_E(rd_addr_E), .rd_wren_E(rd_wren_E),
    .is_load_E(is_load_E),
    .rd_addr_M(rd_addr_M), .rd_wren_M(rd_wren_M),
    .is_load_M(is_load_M), .alu_data_M(alu_data_M),
    .rd_addr_W(rd_addr_W), .rd_wren_W(rd_wren_W),
    .wb_data_W(wb_data_W), .mispredict_E(mispredict_E),
    .src_E(src3), .fwd_sel_E(sel3),
    .stall_F(sf3), .stall_D(sd3),
    .flush_D(fd3), .flush_E(fe3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest non-load producer of a nonzero register supplies it.
  function automatic logic [1:0] ref_sel(int i);
    logic [AW-1:0] r;
    r = rs_addr_E[i];
    if (r == 0) return 2'b00;
    if (rd_wren_M && !is_load_M && rd_addr_M == r) return 2'b10;
    if (rd_wren_W && rd_addr_W == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_src(int i);
    case (ref_sel(i))
      2'b10:   return alu_data_M;
      2'b01:   return wb_data_W;
      default: return rs_data_E[i];
    endcase
  endfunction

  function automatic bit ref_hz();
    bit hit;
    hit = 0;
    for (int i = 0; i < NS; i++)
      if (rs_used_D[i] && rs_addr_D[i] == rd_addr_E) hit = 1;
    return is_load_E && rd_wren_E && rd_addr_E != 0 && hit;
  endfunction

  task automatic check_now();
    bit st;
    logic [3:0] e;
    for (int d = 0; d < 2; d++) begin
      st = !mispredict_E && (rem[d] > 0 || ref_hz());
      e = '0;
      if (rst_ni)
        e = {st, st, mispredict_E, mispredict_E | st};
      chk($sformatf("ctl_ll%0d", lat[d]), ctl[d], e);
    end
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("sel1_%0d", i), sel1[i], ref_sel(i));
      chk($sformatf("sel3_%0d", i), sel3[i], ref_sel(i));
      chk($sformatf("src1_%0d", i), src1[i], ref_src(i));
      chk($sformatf("src3_%0d", i), src3[i], ref_src(i));
    end
  endtask

  // Bubble budget: each hazard buys lat bubbles, a flush cancels them.
  task automatic update();
    for (int d = 0; d < 2; d++) begin
      if (!rst_ni || mispredict_E) rem[d] = 0;
      else if (rem[d] > 0) rem[d]--;
      else if (ref_hz()) rem[d] = lat[d] - 1;
    end
  endtask

  task automatic cycle();
    #2;
    check_now();
    update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rs_addr_D = '0; rs_addr_E = '0; rs_used_D = '0;
    rs_data_E = {$urandom(), $urandom()};
    rd_addr_E = '0; rd_wren_E = 0; is_load_E = 0;
    rd_addr_M = '0; rd_wren_M = 0; is_load_M = 0;
    rd_addr_W = '0; rd_wren_W = 0;
    alu_data_M = $urandom(); wb_data_W = $urandom();
    mispredict_E = 0;
  endtask

  task automatic load_use();
    is_load_E = 1; rd_wren_E = 1; rd_addr_E = 5'd7;
    rs_used_D = 2'b10; rs_addr_D[1] = 5'd7;
  endtask

  int scount;

  initial begin
    rem = '{0, 0};
    idle_in();
    load_use();
    @(negedge clk);
    cycle();
    @(posedge clk); #1 rst_ni = 1;
    @(negedge clk);

    // ALU dependency through M beats W
    idle_in();
    rs_addr_E[0] = 5'd5;
    rd_wren_M = 1; rd_addr_M = 5'd5; alu_data_M = 32'hDEAD_BEEF;
    rd_wren_W = 1; rd_addr_W = 5'd5; wb_data_W = 32'h1234;
    #2;
    chk("alu_src0", src1[0], 32'hDEAD_BEEF);
    chk("alu_sel0", sel3[0], 2'b10);
    chk("alu_ctl", ctl[0], 4'b0000);
    cycle();

    // x0 is never forwarded
    idle_in();
    rd_wren_M = 1; rd_addr_M = 5'd0;
    rs_addr_E[0] = 5'd9;
    #2;
    chk("x0_src1", src1[1], rs_data_E[1]);
    chk("x0_sel1", sel1[1], 2'b00);
    cycle();

    // load-use: one bubble for LL1, three for LL3
    idle_in(); load_use();
    #2;
    chk("lu_ll1_stall", ctl[0], 4'b1101);
    cycle();
    idle_in();
    rs_used_D = 2'b10; rs_addr_D[1] = 5'd7;
    is_load_M = 1; rd_wren_M = 1; rd_addr_M = 5'd7;
    rs_addr_E[1] = 5'd7;
    #2;
    chk("lu_ll1_free", ctl[0], 4'b0000);
    chk("lu_no_mem", sel3[1], 2'b00);
    cycle();
    idle_in();
    rs_addr_E[1] = 5'd7; rd_wren_W = 1; rd_addr_W = 5'd7;
    #2;
    chk("lu_wb_sel", sel1[1], 2'b01);
    chk("lu_wb_src", src1[1], wb_data_W);
    cycle();
    repeat (3) cycle();

    idle_in(); load_use();
    scount = 0;
    for (int k = 0; k < 6; k++) begin
      #2;
      if (sf3) scount++;
      check_now(); update();
      @(negedge clk);
      idle_in();
    end
    chk("ll3_bubbles", scount, 3);

    // mispredict in the second stall cycle
    idle_in(); load_use();
    cycle();
    idle_in(); mispredict_E = 1;
    #2;
    chk("mp_ctl3", ctl[1], 4'b0011);
    cycle();
    idle_in();
    #2;
    chk("mp_after", ctl[1], 4'b0000);
    cycle();

    // async reset mid-stall
    idle_in(); load_use();
    cycle();
    idle_in();
    #2; check_now();
    #1 rst_ni = 0;
    #1;
    chk("rst_async", ctl[1], 4'b0000);
    check_now(); update();
    @(posedge clk); #1 rst_ni = 1;
    @(negedge clk);
    #2;
    chk("rst_release", ctl[1], 4'b0000);
    cycle();

    // matching address but source unused
    idle_in(); load_use(); rs_used_D = 2'b00;
    #2;
    chk("unused_src", ctl[0] | ctl[1], 4'b0000);
    cycle();

    for (int k = 0; k < 400; k++) begin
      rs_addr_D = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rs_addr_E = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rs_used_D = 2'($urandom);
      rs_data_E = {$urandom(), $urandom()};
      rd_addr_E = 5'($urandom_range(0, 3));
      rd_addr_M = 5'($urandom_range(0, 3));
      rd_addr_W = 5'($urandom_range(0, 3));
      {rd_wren_E, rd_wren_M, rd_wren_W} = 3'($urandom);
      {is_load_E, is_load_M} = 2'($urandom);
      alu_data_M = $urandom(); wb_data_W = $urandom();
      mispredict_E = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
